spi_master: RTL and testbench
=============================

Name: spi_master

Overview:
- Byte-oriented SPI mode 0 master (CPOL=0, CPHA=0, MSB first).
- Drives SCK, SSEL and MOSI into the FPGA SPI slave stage and captures MISO. It is the upstream stage that feeds the slave.
- Local logic offers bytes over a valid/ready handshake. tx_last groups bytes into one SSEL-low transaction.
- Each received byte is returned on a one-cycle rx_valid strobe.

Parameters:
- CLK_DIV, 8: clk cycles per SCK half-period. Legal range 2..255. Must be >= 8 when the slave's 3-flop SCK synchroniser and MISO return path run on the same clk.
- CS_SETUP_CYC, 8: clk cycles from SSEL fall to the first SCK rise. The SCK-low half of bit 7 counts toward this; effective setup is max(CS_SETUP_CYC, CLK_DIV).
- CS_GAP_CYC, 16: minimum clk cycles SSEL stays high between transactions.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- tx_data  in  8  byte to send
- tx_last  in  1  this byte ends the transaction; sampled with tx_data
- tx_valid  in  1  tx_data/tx_last valid
- tx_ready  out  1  master accepts the byte this cycle
- rx_data  out  8  last received byte; held until the next rx_valid
- rx_valid  out  1  one-cycle strobe, rx_data new
- busy  out  1  high whenever SSEL is low or the gap timer runs
- SCK  out  1  SPI clock, idle low
- SSEL  out  1  slave select, active low
- MOSI  out  1  master data out
- MISO  in  1  slave data in, asynchronous; 2-flop synchronised internally

Behaviour:
- Reset values (async on rst): SCK=0, SSEL=1, MOSI=0, tx_ready=0, rx_valid=0, rx_data=8'h00, busy=0, FSM=IDLE, all counters 0.
- Handshake: a byte is accepted on a clk edge with tx_valid && tx_ready. tx_ready is combinational from state only (IDLE or WAIT_NEXT), never from tx_valid.
- FSM states:
  - IDLE: tx_ready=1. On accept: load shifter, MOSI=tx_data[7] next cycle, SSEL=0, go SETUP.
  - SETUP: count CS_SETUP_CYC with SCK low, then go BIT_HI.
  - BIT_HI: SCK=1 for CLK_DIV cycles. On entry, sample synchronised MISO into rx shifter LSB.
  - BIT_LO: SCK=0 for CLK_DIV cycles. On entry, shift MOSI to the next bit.
  - Bit sequencing: a 3-bit counter counts 8 HI/LO pairs. After the 8th HI, SCK falls, rx_valid pulses and rx_data is updated in the same cycle.
  - After the 8th bit: if the latched last flag is set, go HOLD; otherwise go WAIT_NEXT.
  - WAIT_NEXT: SSEL stays 0, SCK stays 0, tx_ready=1. On accept, load the shifter and drive MOSI=bit7. Then SCK low for CLK_DIV cycles before the next BIT_HI. Stalls indefinitely with no timeout.
  - HOLD: SCK low for CLK_DIV cycles, then SSEL=1, go GAP.
  - GAP: count CS_GAP_CYC, then go IDLE.
- Timing per byte: 8 bits take 16*CLK_DIV clk cycles. First SCK rise occurs max(CS_SETUP_CYC, CLK_DIV) cycles after SSEL falls.
- MOSI changes only on SCK falling edges or while SCK is low before the first rise; it never changes on a rise.
- Boundaries:
  - tx_valid asserted in SETUP/BIT/HOLD/GAP: ignored until ready.
  - tx_valid held continuously with tx_last=0: back-to-back bytes with exactly one extra low half-period between bytes.
  - rst mid-byte: SSEL returns high immediately (async), no rx_valid, partial byte discarded.
- Counters are saturating-free down-counters reloaded per phase. A parameter value of 0 for CS_SETUP_CYC or CS_GAP_CYC means 1 cycle.

Optional Feature:
- Macro SPI_MASTER_LOOPBACK_EN.
- Defined: the rx shifter samples the internal MOSI register instead of the MISO synchroniser. rx_data then equals the transmitted byte, for board self-test without a slave. The MISO pin is unused.
- Undefined: normal MISO sampling. No loopback mux exists in the netlist.

Decomposition:
- Package spi_pkg:
  - typedef enum spi_master_state_t {IDLE, SETUP, BIT_HI, BIT_LO, WAIT_NEXT, HOLD, GAP}
  - localparam SPI_BYTE_W = 8
  - default CLK_DIV/CS timing constants, shared with the slave bench.
- One natural sub-module, spi_clk_div: a reloadable down-counter producing a phase-done tick. It is used for the half-period, setup and gap timing.

Test Plan:
- Single byte tx_data=8'hA5, tx_last=1, against the slave returning 8'h41 -> MOSI sampled at rises reads 1,0,1,0,0,1,0,1; rx_data=8'h41 with one rx_valid; SSEL low for exactly CS_SETUP+16*CLK_DIV+CLK_DIV cycles.
- Three-byte transaction 8'h01,8'h02,8'h03 (last on third), tx_valid held -> SSEL stays low throughout; 24 SCK rises; 3 rx_valid pulses; slave byte_received fires 3 times.
- WAIT_NEXT stall: send 8'h10 with tx_last=0, withhold tx_valid 100 cycles -> SCK=0, SSEL=0, tx_ready=1 throughout; then 8'h20 with tx_last=1 completes normally.
- Back-to-back transactions -> SSEL high >= CS_GAP_CYC cycles between them; busy is high through the gap; the slave's message counter increments by 2.
- rst asserted at the 4th SCK rise -> SSEL=1, SCK=0 the same cycle, no rx_valid; a following 8'hFF transfer is correct.
- With SPI_MASTER_LOOPBACK_EN, send 8'h3C with MISO tied to 0 -> rx_data=8'h3C.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and default timing constants for the SPI mode-0 master and
// the slave-side benches.
package spi_pkg;

  localparam int unsigned SPI_BYTE_W           = 8;
  localparam int unsigned SPI_CNT_W            = 16;
  localparam int unsigned SPI_DEF_CLK_DIV      = 8;
  localparam int unsigned SPI_DEF_CS_SETUP_CYC = 8;
  localparam int unsigned SPI_DEF_CS_GAP_CYC   = 16;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SETUP     = 3'd1,
    BIT_HI    = 3'd2,
    BIT_LO    = 3'd3,
    WAIT_NEXT = 3'd4,
    HOLD      = 3'd5,
    GAP       = 3'd6
  } spi_master_state_t;

  // Larger of two elaboration-time values, used to fold parameter minimums.
  function automatic int unsigned spi_max(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/spi_clk_div.sv
// Reloadable phase timer: load N and done_o is high during the N-th cycle
// after the load, so the owner leaves the phase after exactly N cycles.
module spi_clk_div
  import spi_pkg::*;
#(
  parameter int unsigned CNT_W = SPI_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             done_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q;

  // Reload on request, otherwise count down and park at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Counter register; done is registered from the next count so it tracks cnt_q == 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      done_q <= (cnt_d == CNT_W'(1));
    end
  end

  assign done_o = done_q;

endmodule

// File: rtl/spi_master.sv
// Byte-oriented SPI mode 0 master (CPOL=0, CPHA=0, MSB first).
// Optional feature: define SPI_MASTER_LOOPBACK_EN to sample the internal MOSI
// register instead of MISO (board self-test without a slave).
module spi_master
  import spi_pkg::*;
#(
  parameter int unsigned CLK_DIV      = SPI_DEF_CLK_DIV,
  parameter int unsigned CS_SETUP_CYC = SPI_DEF_CS_SETUP_CYC,
  parameter int unsigned CS_GAP_CYC   = SPI_DEF_CS_GAP_CYC
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [SPI_BYTE_W-1:0] tx_data,
  input  logic                  tx_last,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [SPI_BYTE_W-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  busy,
  output logic                  SCK,
  output logic                  SSEL,
  output logic                  MOSI,
  input  logic                  MISO
);

  localparam int unsigned CNT_W     = SPI_CNT_W;
  localparam int unsigned SETUP_EFF = spi_max(spi_max(CS_SETUP_CYC, 1), CLK_DIV);
  localparam int unsigned GAP_EFF   = spi_max(CS_GAP_CYC, 1);

  localparam logic [CNT_W-1:0] HALF_LD  = CNT_W'(CLK_DIV);
  // The WAIT_NEXT cycle that accepts the byte counts as the first low cycle.
  localparam logic [CNT_W-1:0] NEXT_LD  = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_EFF);
  localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(GAP_EFF);

  spi_master_state_t state_q, state_d;

  logic [SPI_BYTE_W-1:0] tx_sh_q, rx_sh_q, rx_data_q;
  logic [2:0]            bit_cnt_q;
  logic                  last_q;
  logic                  sck_q, ssel_q, mosi_q, rx_valid_q, busy_q;

  logic             ready_c, accept_c, phase_done_c, load_c, rx_bit_c;
  logic [CNT_W-1:0] load_val_c;

  assign ready_c  = !rst && ((state_q == IDLE) || (state_q == WAIT_NEXT));
  assign accept_c = tx_valid && ready_c;

  // One timer serves setup, half-period, hold and gap phases.
  spi_clk_div #(.CNT_W(CNT_W)) u_clk_div (
    .clk        (clk),
    .rst        (rst),
    .load_i     (load_c),
    .load_val_i (load_val_c),
    .done_o     (phase_done_c)
  );

`ifdef SPI_MASTER_LOOPBACK_EN
  logic unused_miso;
  assign unused_miso = MISO;
  assign rx_bit_c    = mosi_q;
`else
  logic miso_meta_q, miso_sync_q;

  // Two-flop synchroniser for the asynchronous MISO pin.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      miso_meta_q <= 1'b0;
      miso_sync_q <= 1'b0;
    end else begin
      miso_meta_q <= MISO;
      miso_sync_q <= miso_meta_q;
    end
  end

  assign rx_bit_c = miso_sync_q;
`endif

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state plus timer reload on every phase change.
  always_comb begin
    state_d    = state_q;
    load_c     = 1'b0;
    load_val_c = '0;
    case (state_q)
      IDLE:      if (accept_c)     state_d = SETUP;
      SETUP:     if (phase_done_c) state_d = BIT_HI;
      BIT_HI:    if (phase_done_c) state_d = BIT_LO;
      BIT_LO: begin
        if (phase_done_c) begin
          if (bit_cnt_q == 3'd7) begin
            state_d = last_q ? HOLD : WAIT_NEXT;
          end else begin
            state_d = BIT_HI;
          end
        end
      end
      WAIT_NEXT: if (accept_c)     state_d = SETUP;
      HOLD:      if (phase_done_c) state_d = GAP;
      GAP:       if (phase_done_c) state_d = IDLE;
      default:                     state_d = IDLE;
    endcase
    if (state_d != state_q) begin
      load_c = 1'b1;
      case (state_d)
        SETUP:               load_val_c = (state_q == IDLE) ? SETUP_LD : NEXT_LD;
        BIT_HI, BIT_LO, HOLD: load_val_c = HALF_LD;
        GAP:                 load_val_c = GAP_LD;
        default:             load_val_c = '0;
      endcase
    end
  end

  // Shifters, bit counter and pin registers, all driven from the upcoming state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_sh_q    <= '0;
      rx_sh_q    <= '0;
      rx_data_q  <= '0;
      bit_cnt_q  <= '0;
      last_q     <= 1'b0;
      sck_q      <= 1'b0;
      ssel_q     <= 1'b1;
      mosi_q     <= 1'b0;
      rx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      if (accept_c) begin
        tx_sh_q   <= tx_data;
        mosi_q    <= tx_data[SPI_BYTE_W-1];
        last_q    <= tx_last;
        bit_cnt_q <= '0;
      end
      if ((state_d == BIT_HI) && (state_q != BIT_HI)) begin
        rx_sh_q <= {rx_sh_q[SPI_BYTE_W-2:0], rx_bit_c};
      end
      if ((state_q == BIT_HI) && (state_d == BIT_LO)) begin
        tx_sh_q <= {tx_sh_q[SPI_BYTE_W-2:0], 1'b0};
        mosi_q  <= tx_sh_q[SPI_BYTE_W-2];
        if (bit_cnt_q == 3'd7) begin
          rx_valid_q <= 1'b1;
          rx_data_q  <= rx_sh_q;
        end
      end
      if ((state_q == BIT_LO) && (state_d == BIT_HI)) begin
        bit_cnt_q <= bit_cnt_q + 3'd1;
      end
      sck_q  <= (state_d == BIT_HI);
      ssel_q <= (state_d == IDLE) || (state_d == GAP);
      busy_q <= (state_d != IDLE);
    end
  end

  assign tx_ready = ready_c;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign busy     = busy_q;
  assign SCK      = sck_q;
  assign SSEL     = ssel_q;
  assign MOSI     = mosi_q;

endmodule

// File: tb/tb_spi_master.sv
// Self-checking bench for spi_master with a behavioural mode-0 slave.
`timescale 1ns/1ps
module tb_spi_master;

  localparam int unsigned CLK_DIV   = 8;
  localparam int unsigned CS_SETUP  = 8;
  localparam int unsigned CS_GAP    = 16;
  localparam int unsigned SETUP_EFF = (CS_SETUP > CLK_DIV) ? CS_SETUP : CLK_DIV;
  localparam int unsigned LOW_1B    = SETUP_EFF + 16*CLK_DIV + CLK_DIV;
  localparam int unsigned LOW_3B    = SETUP_EFF + 3*16*CLK_DIV + 2*CLK_DIV + CLK_DIV;
`ifdef SPI_MASTER_LOOPBACK_EN
  localparam bit LB = 1'b1;
`else
  localparam bit LB = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_last, tx_valid, tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid, busy, SCK, SSEL, MOSI, miso_pin, slv_miso;

  assign miso_pin = LB ? 1'b0 : slv_miso;

  spi_master #(.CLK_DIV(CLK_DIV), .CS_SETUP_CYC(CS_SETUP), .CS_GAP_CYC(CS_GAP)) dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_last(tx_last), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy),
    .SCK(SCK), .SSEL(SSEL), .MOSI(MOSI), .MISO(miso_pin)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  logic [7:0] exp_rx_q[$], exp_mosi_q[$], slv_q[$];
  bit         slv_first_q[$];
  int sck_rises = 0, rx_count = 0, byte_rcvd = 0, ssel_falls = 0;
  int low_run = 0, last_low = 0, hi_run = 0, last_gap = 0, busy_run = 0, last_busy_gap = 0;

  logic [7:0] slv_sh = 8'h00, slv_cap = 8'h00;
  int         slv_bit = 0;
  bit         slv_dummy;

  initial slv_miso = 1'b0;

  function automatic logic [7:0] exp_of(input logic [7:0] tx, input logic [7:0] resp);
    return LB ? tx : resp;
  endfunction

  // Slave: present a new byte's MSB when selected.
  always @(negedge SSEL) begin
    ssel_falls++;
    slv_bit = 0;
    if (slv_q.size() > 0) begin
      slv_sh    = slv_q.pop_front();
      slv_dummy = slv_first_q.pop_front();
    end else begin
      slv_sh = 8'h00;
    end
    slv_miso = slv_sh[7];
  end

  // Slave: capture MOSI on rises, check each full byte against what was sent.
  always @(posedge SCK) begin
    sck_rises++;
    slv_cap = {slv_cap[6:0], MOSI};
    slv_bit++;
    if (slv_bit == 8) begin
      logic [7:0] e;
      slv_bit = 0;
      byte_rcvd++;
      total++;
      if (exp_mosi_q.size() == 0) begin
        bad++;
        $display("FAIL mosi_byte: got %02h with nothing expected", slv_cap);
      end else begin
        e = exp_mosi_q.pop_front();
        if (slv_cap !== e) begin
          bad++;
          $display("FAIL mosi_byte: got %02h expected %02h", slv_cap, e);
        end
      end
    end
  end

  // Slave: shift MISO on falls; at a byte boundary load the next byte of the same transaction.
  always @(negedge SCK) begin
    if (SSEL === 1'b0) begin
      if (slv_bit == 0) begin
        if (slv_q.size() > 0 && slv_first_q[0] == 1'b0) begin
          slv_sh    = slv_q.pop_front();
          slv_dummy = slv_first_q.pop_front();
        end else begin
          slv_sh = 8'h00;
        end
      end else begin
        slv_sh = {slv_sh[6:0], 1'b0};
      end
      slv_miso = slv_sh[7];
    end
  end

  // Receive scoreboard and SSEL/busy interval measurement.
  always @(negedge clk) begin
    if (rx_valid === 1'b1) begin
      logic [7:0] e;
      rx_count++;
      total++;
      if (exp_rx_q.size() == 0) begin
        bad++;
        $display("FAIL rx_byte: got %02h with nothing expected", rx_data);
      end else begin
        e = exp_rx_q.pop_front();
        if (rx_data !== e) begin
          bad++;
          $display("FAIL rx_byte: got %02h expected %02h", rx_data, e);
        end
      end
    end
    if (SSEL === 1'b0) begin
      low_run++;
      if (hi_run > 0) begin
        last_gap      = hi_run;
        last_busy_gap = busy_run;
      end
      hi_run   = 0;
      busy_run = 0;
    end else if (SSEL === 1'b1) begin
      if (low_run > 0) last_low = low_run;
      low_run = 0;
      hi_run++;
      if (busy === 1'b1) busy_run++;
    end
  end

  task automatic expect_xfer(input logic [7:0] tx, input logic [7:0] resp, input bit first);
    slv_q.push_back(resp);
    slv_first_q.push_back(first);
    exp_rx_q.push_back(exp_of(tx, resp));
  endtask

  task automatic send_byte(input logic [7:0] d, input logic last);
    int waited = 0;
    @(negedge clk);
    tx_data  = d;
    tx_last  = last;
    tx_valid = 1'b1;
    exp_mosi_q.push_back(d);
    while (tx_ready !== 1'b1 && waited < 2000) begin
      @(negedge clk);
      waited++;
    end
    total++;
    if (tx_ready !== 1'b1) begin
      bad++;
      $display("FAIL accept_timeout: tx_ready=%b after %0d cycles, required 1", tx_ready, waited);
    end else begin
      @(posedge clk);
    end
  endtask

  task automatic drop_valid();
    @(negedge clk);
    tx_valid = 1'b0;
    tx_last  = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    @(negedge clk);
    while (!(SSEL === 1'b1 && busy === 1'b0 && tx_ready === 1'b1) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n >= 3000) begin
      bad++;
      $display("FAIL done_timeout: SSEL=%b busy=%b, required SSEL=1 busy=0", SSEL, busy);
    end
    total++;
    if (exp_rx_q.size() != 0) begin
      bad++;
      $display("FAIL rx_missing: %0d bytes outstanding, required 0", exp_rx_q.size());
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++;
    if ({SCK, SSEL, MOSI, tx_ready, rx_valid, busy} !== 6'b010000) begin
      bad++;
      $display("FAIL reset_pins: SCK,SSEL,MOSI,ready,rx_valid,busy=%b required 010000",
               {SCK, SSEL, MOSI, tx_ready, rx_valid, busy});
    end
    total++;
    if (rx_data !== 8'h00) begin
      bad++;
      $display("FAIL reset_rx_data: got %02h required 00", rx_data);
    end
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (tx_ready !== 1'b1 || SSEL !== 1'b1) begin
      bad++;
      $display("FAIL idle_ready: tx_ready=%b SSEL=%b required 1 1", tx_ready, SSEL);
    end
  endtask

  task automatic test_single();
    int r0 = rx_count, s0 = sck_rises;
    expect_xfer(8'hA5, 8'h41, 1'b1);
    send_byte(8'hA5, 1'b1);
    drop_valid();
    wait_done();
    total++;
    if (last_low != LOW_1B) begin
      bad++;
      $display("FAIL single_ssel_low: %0d cycles required %0d", last_low, LOW_1B);
    end
    total++;
    if (sck_rises - s0 != 8) begin
      bad++;
      $display("FAIL single_sck_rises: %0d required 8", sck_rises - s0);
    end
    total++;
    if (rx_count - r0 != 1) begin
      bad++;
      $display("FAIL single_rx_count: %0d required 1", rx_count - r0);
    end
    total++;
    if (rx_data !== exp_of(8'hA5, 8'h41)) begin
      bad++;
      $display("FAIL single_rx_hold: got %02h required %02h", rx_data, exp_of(8'hA5, 8'h41));
    end
  endtask

  task automatic test_multi();
    int r0 = rx_count, s0 = sck_rises, b0 = byte_rcvd, f0 = ssel_falls;
    expect_xfer(8'h01, 8'hC3, 1'b1);
    expect_xfer(8'h02, 8'h5A, 1'b0);
    expect_xfer(8'h03, 8'h7E, 1'b0);
    send_byte(8'h01, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'h03, 1'b1);
    drop_valid();
    wait_done();
    total++;
    if (ssel_falls - f0 != 1) begin
      bad++;
      $display("FAIL multi_ssel_falls: %0d required 1", ssel_falls - f0);
    end
    total++;
    if (last_low != LOW_3B) begin
      bad++;
      $display("FAIL multi_ssel_low: %0d cycles required %0d", last_low, LOW_3B);
    end
    total++;
    if (sck_rises - s0 != 24 || rx_count - r0 != 3 || byte_rcvd - b0 != 3) begin
      bad++;
      $display("FAIL multi_counts: rises=%0d rx=%0d slave_bytes=%0d required 24 3 3",
               sck_rises - s0, rx_count - r0, byte_rcvd - b0);
    end
  endtask

  task automatic test_wait_next();
    int r0 = rx_count, s0 = sck_rises, n = 0;
    bit ok = 1'b1;
    expect_xfer(8'h10, 8'h96, 1'b1);
    expect_xfer(8'h20, 8'h69, 1'b0);
    send_byte(8'h10, 1'b0);
    drop_valid();
    while (tx_ready !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (SCK !== 1'b0 || SSEL !== 1'b0 || tx_ready !== 1'b1) ok = 1'b0;
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL stall_hold: SCK=%b SSEL=%b tx_ready=%b required 0 0 1", SCK, SSEL, tx_ready);
    end
    send_byte(8'h20, 1'b1);
    drop_valid();
    wait_done();
    total++;
    if (sck_rises - s0 != 16 || rx_count - r0 != 2) begin
      bad++;
      $display("FAIL stall_counts: rises=%0d rx=%0d required 16 2", sck_rises - s0, rx_count - r0);
    end
  endtask

  task automatic test_back_to_back();
    int r0 = rx_count, f0 = ssel_falls;
    expect_xfer(8'h81, 8'h18, 1'b1);
    expect_xfer(8'h42, 8'h24, 1'b1);
    send_byte(8'h81, 1'b1);
    send_byte(8'h42, 1'b1);
    drop_valid();
    wait_done();
    total++;
    if (ssel_falls - f0 != 2 || rx_count - r0 != 2) begin
      bad++;
      $display("FAIL b2b_counts: transactions=%0d rx=%0d required 2 2", ssel_falls - f0, rx_count - r0);
    end
    total++;
    if (last_gap < CS_GAP) begin
      bad++;
      $display("FAIL b2b_gap: SSEL high %0d cycles required >= %0d", last_gap, CS_GAP);
    end
    total++;
    if (last_busy_gap < CS_GAP) begin
      bad++;
      $display("FAIL b2b_busy: busy high %0d gap cycles required >= %0d", last_busy_gap, CS_GAP);
    end
  endtask

  task automatic test_reset_mid();
    int r0 = rx_count, s0 = sck_rises, n = 0;
    slv_q.push_back(8'h99);
    slv_first_q.push_back(1'b1);
    send_byte(8'h5A, 1'b1);
    drop_valid();
    while ((sck_rises - s0) < 4 && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
    end
    rst = 1'b1;
    #1;
    total++;
    if (SSEL !== 1'b1 || SCK !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL rst_mid_pins: SSEL=%b SCK=%b busy=%b required 1 0 0", SSEL, SCK, busy);
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    exp_mosi_q.delete();
    slv_q.delete();
    slv_first_q.delete();
    @(negedge clk);
    total++;
    if (rx_count != r0 || rx_data !== 8'h00) begin
      bad++;
      $display("FAIL rst_mid_discard: rx pulses=%0d rx_data=%02h required 0 00", rx_count - r0, rx_data);
    end
    expect_xfer(8'hFF, 8'h3E, 1'b1);
    send_byte(8'hFF, 1'b1);
    drop_valid();
    wait_done();
    total++;
    if (rx_count - r0 != 1 || rx_data !== exp_of(8'hFF, 8'h3E)) begin
      bad++;
      $display("FAIL rst_mid_recover: rx=%0d data=%02h required 1 %02h",
               rx_count - r0, rx_data, exp_of(8'hFF, 8'h3E));
    end
  endtask

  task automatic test_loopback();
    expect_xfer(8'h3C, 8'h00, 1'b1);
    send_byte(8'h3C, 1'b1);
    drop_valid();
    wait_done();
    total++;
    if (rx_data !== 8'h3C) begin
      bad++;
      $display("FAIL loopback_rx: got %02h required 3C", rx_data);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b0;
    tx_data  = 8'h00;
    tx_last  = 1'b0;
    tx_valid = 1'b0;
    #1 rst = 1'b1;
    test_reset();
    test_single();
    test_multi();
    test_wait_next();
    test_back_to_back();
    test_reset_mid();
    if (LB) test_loopback();
    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
